rx_glitch_filter: RTL and testbench

RX_GLITCH_FILTER -- requirements
Module: rx_glitch_filter

---
 rtl/rx_glitch_filter_pkg.sv | 21 ++
 rtl/rx_glitch_filter_if.sv | 31 +++
 rtl/rx_glitch_filter_channel.sv | 90 +++++++++
 rtl/rx_glitch_filter.sv | 49 ++++
 tb/tb_rx_glitch_filter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/rx_glitch_filter_pkg.sv
// Shared defaults and helpers for the rx glitch filter: counter sizing, thresholds and the
// edge classification used by each channel.
package rx_filter_pkg;

  localparam int unsigned DEF_CNT_W       = 2;
  localparam int unsigned DEF_HI_TH       = 3;
  localparam int unsigned DEF_LO_TH       = 0;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Largest value a counter of the given width can hold.
  function automatic int unsigned cnt_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  typedef enum logic [1:0] {
    EdgeNone,
    EdgeRise,
    EdgeFall
  } edge_e;

endpackage

// File: rtl/rx_glitch_filter_if.sv
// Bundle of the strobe, mode and per-channel line signals between a driver and the filter.
interface rx_glitch_filter_if #(
  parameter int unsigned NUM_CH = 1
) ();

  logic              sample_tick;
  logic              filt_en;
  logic [NUM_CH-1:0] rxd_raw;
  logic [NUM_CH-1:0] rxd_bit;
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] fall_pulse;

  modport master (
    output sample_tick,
    output filt_en,
    output rxd_raw,
    input  rxd_bit,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  sample_tick,
    input  filt_en,
    input  rxd_raw,
    output rxd_bit,
    output rise_pulse,
    output fall_pulse
  );

endinterface

// File: rtl/rx_glitch_filter_channel.sv
// One filter channel: synchronizer, saturating up/down counter with hysteresis decision,
// and registered rise/fall strobes aligned with the filtered level change.
module rx_filter_channel
  import rx_filter_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned HI_TH       = DEF_HI_TH,
  parameter int unsigned LO_TH       = DEF_LO_TH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_tick,
  input  logic filt_en,
  input  logic rxd_raw,
  output logic rxd_bit,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] HiTh   = CNT_W'(HI_TH);
  localparam logic [CNT_W-1:0] LoTh   = CNT_W'(LO_TH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   bit_q, bit_d;
  edge_e                  edge_d;

  // Synchronizer runs every clk; only the counter is gated by the sample strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d = cnt_q;
    bit_d = bit_q;
    if (sample_tick) begin
      if (filt_en) begin
        // Decision uses the counter value before this tick's update.
        if (cnt_q >= HiTh) begin
          bit_d = 1'b1;
        end else if (cnt_q <= LoTh) begin
          bit_d = 1'b0;
        end
        if (s && (cnt_q != CntMax)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (!s && (cnt_q != '0)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else begin
        bit_d = s;
        cnt_d = s ? CntMax : '0;
      end
    end
  end

  always_comb begin
    edge_d = EdgeNone;
    if (bit_d && !bit_q) begin
      edge_d = EdgeRise;
    end else if (!bit_d && bit_q) begin
      edge_d = EdgeFall;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= CntMax;
      bit_q      <= 1'b1;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      rise_pulse <= (edge_d == EdgeRise);
      fall_pulse <= (edge_d == EdgeFall);
    end
  end

  assign rxd_bit = bit_q;

endmodule

// File: rtl/rx_glitch_filter.sv
// Multi-channel rx glitch filter: NUM_CH independent channels sharing only the clock, reset,
// sample strobe and filter-enable.
module rx_glitch_filter
  import rx_filter_pkg::*;
#(
  parameter int unsigned NUM_CH      = 1,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned HI_TH       = DEF_HI_TH,
  parameter int unsigned LO_TH       = DEF_LO_TH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input logic              clk,
  input logic              rst,
  rx_glitch_filter_if.slave bus
);

  if ((NUM_CH < 1) || (NUM_CH > 16) || (CNT_W < 1) || (CNT_W > 8) ||
      (SYNC_STAGES < 2) || (SYNC_STAGES > 4) ||
      (LO_TH >= HI_TH) || (HI_TH > cnt_max(CNT_W))) begin : g_bad_params
    $fatal(1, "rx_glitch_filter: illegal parameter combination");
  end

  logic [NUM_CH-1:0] bit_w;
  logic [NUM_CH-1:0] rise_w;
  logic [NUM_CH-1:0] fall_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rx_filter_channel #(
      .CNT_W       (CNT_W),
      .HI_TH       (HI_TH),
      .LO_TH       (LO_TH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (bus.sample_tick),
      .filt_en     (bus.filt_en),
      .rxd_raw     (bus.rxd_raw[i]),
      .rxd_bit     (bit_w[i]),
      .rise_pulse  (rise_w[i]),
      .fall_pulse  (fall_w[i])
    );
  end

  assign bus.rxd_bit    = bit_w;
  assign bus.rise_pulse = rise_w;
  assign bus.fall_pulse = fall_w;

endmodule

// File: tb/tb_rx_glitch_filter.sv
// Scoreboard bench: directed ticks push hand-computed expectations, a monitor compares them
// against two filter instances (4-channel default, and 1-channel wide-counter).
module tb_rx_glitch_filter;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       tick  = 1'b0;
  logic       en    = 1'b1;
  logic [3:0] raw_a = 4'hF;
  logic       raw_b = 1'b1;

  always #5 clk = ~clk;

  rx_glitch_filter_if #(.NUM_CH(4)) bus_a ();
  rx_glitch_filter_if #(.NUM_CH(1)) bus_b ();

  assign bus_a.sample_tick = tick;
  assign bus_a.filt_en     = en;
  assign bus_a.rxd_raw     = raw_a;
  assign bus_b.sample_tick = tick;
  assign bus_b.filt_en     = en;
  assign bus_b.rxd_raw     = raw_b;

  rx_glitch_filter #(
    .NUM_CH (4)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  rx_glitch_filter #(
    .NUM_CH      (1),
    .CNT_W       (4),
    .HI_TH       (12),
    .LO_TH       (3),
    .SYNC_STAGES (2)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct packed {
    logic [3:0] a_bit;
    logic [3:0] a_rise;
    logic [3:0] a_fall;
    logic       b_bit;
    logic       b_rise;
    logic       b_fall;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] lvl_a;
  logic       lvl_b;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: on tick cycles pop the scoreboard; otherwise levels must hold and pulses stay 0.
  always begin : mon
    logic was_tick, was_rst;
    exp_t e;
    @(posedge clk);
    was_tick = tick;
    was_rst  = rst;
    #1;
    if (was_rst) begin
      lvl_a = 4'hF;
      lvl_b = 1'b1;
      check("rst_a_bit", bus_a.rxd_bit, 4'hF);
      check("rst_a_pulse", bus_a.rise_pulse | bus_a.fall_pulse, 4'h0);
      check("rst_b_bit", {3'b0, bus_b.rxd_bit}, 4'h1);
      check("rst_b_pulse", {2'b0, bus_b.rise_pulse, bus_b.fall_pulse}, 4'h0);
    end else if (was_tick) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL tick_unexpected: no expectation queued at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("a_bit", bus_a.rxd_bit, e.a_bit);
        check("a_rise", bus_a.rise_pulse, e.a_rise);
        check("a_fall", bus_a.fall_pulse, e.a_fall);
        check("b_bit", {3'b0, bus_b.rxd_bit}, {3'b0, e.b_bit});
        check("b_rise", {3'b0, bus_b.rise_pulse}, {3'b0, e.b_rise});
        check("b_fall", {3'b0, bus_b.fall_pulse}, {3'b0, e.b_fall});
        lvl_a = e.a_bit;
        lvl_b = e.b_bit;
      end
    end else begin
      check("idle_a_bit", bus_a.rxd_bit, lvl_a);
      check("idle_a_pulse", bus_a.rise_pulse | bus_a.fall_pulse, 4'h0);
      check("idle_b_bit", {3'b0, bus_b.rxd_bit}, {3'b0, lvl_b});
      check("idle_b_pulse", {2'b0, bus_b.rise_pulse, bus_b.fall_pulse}, 4'h0);
    end
  end

  task automatic do_tick(input logic [3:0] ab, input logic [3:0] ar, input logic [3:0] af,
                         input logic bb, input logic br, input logic bf);
    repeat (15) @(negedge clk);
    tick = 1'b1;
    exp_q.push_back({ab, ar, af, bb, br, bf});
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Tick where channel B is expected idle-high.
  task automatic tick_a(input logic [3:0] ab, input logic [3:0] ar, input logic [3:0] af);
    do_tick(ab, ar, af, 1'b1, 1'b0, 1'b0);
  endtask

  // Tick where channel A is expected idle-high.
  task automatic tick_b(input logic bb, input logic bf);
    do_tick(4'hF, 4'h0, 4'h0, bb, 1'b0, bf);
  endtask

  task automatic reset_dut(input logic [3:0] ra);
    @(negedge clk);
    rst   = 1'b1;
    raw_a = ra;
    raw_b = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Channel 0 held low from reset: falls on the 4th tick.
    reset_dut(4'hE);
    repeat (3) tick_a(4'hF, 4'h0, 4'h0);
    tick_a(4'hE, 4'h0, 4'h1);
    tick_a(4'hE, 4'h0, 4'h0);

    // Two-tick low glitch on channel 0: counter dips to 1, output stays high.
    reset_dut(4'hF);
    tick_a(4'hF, 4'h0, 4'h0);
    raw_a = 4'hE;
    repeat (2) tick_a(4'hF, 4'h0, 4'h0);
    raw_a = 4'hF;
    repeat (3) tick_a(4'hF, 4'h0, 4'h0);

    // Bypass, then back to filtering: counter was loaded with 0, so rise takes 4 ticks.
    reset_dut(4'hF);
    en = 1'b0;
    tick_a(4'hF, 4'h0, 4'h0);
    raw_a = 4'hE;
    tick_a(4'hE, 4'h0, 4'h1);
    tick_a(4'hE, 4'h0, 4'h0);
    en    = 1'b1;
    raw_a = 4'hF;
    repeat (3) tick_a(4'hE, 4'h0, 4'h0);
    tick_a(4'hF, 4'h1, 4'h0);

    // Only channel 2 low, then reset in the middle of its climb back.
    reset_dut(4'hB);
    repeat (3) tick_a(4'hF, 4'h0, 4'h0);
    tick_a(4'hB, 4'h0, 4'h4);
    raw_a = 4'hF;
    repeat (2) tick_a(4'hB, 4'h0, 4'h0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_bit", bus_a.rxd_bit, 4'hF);
    check("async_rst_pulse", bus_a.rise_pulse | bus_a.fall_pulse, 4'h0);
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    raw_a = 4'h7;
    repeat (3) tick_a(4'hF, 4'h0, 4'h0);
    tick_a(4'h7, 4'h0, 4'h8);

    // Wide counter: long low settles to 0, then 5-tick toggling stays inside the band.
    reset_dut(4'hF);
    raw_b = 1'b0;
    repeat (12) tick_b(1'b1, 1'b0);
    tick_b(1'b0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      raw_b = 1'b1;
      repeat (5) tick_b(1'b0, 1'b0);
      raw_b = 1'b0;
      repeat (5) tick_b(1'b0, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("queue_drain", 4'(exp_q.size()), 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
